// File: rtl/arb_requester_if.sv
// Bundle of the upstream beat port, the arbiter req/gnt pair and the shared-bus beat port.
// slave = requester side, master = the surrounding environment.
interface arb_requester_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              req;
  logic              gnt;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [CW-1:0]     burst_cnt;
  logic              ovf_err;

  modport slave (
    input  in_valid, in_data, in_last, gnt,
    output in_ready, req, out_valid, out_data, out_last, burst_cnt, ovf_err
  );

  modport master (
    output in_valid, in_data, in_last, gnt,
    input  in_ready, req, out_valid, out_data, out_last, burst_cnt, ovf_err
  );
endinterface

// File: rtl/arb_requester.sv
// Client-side requester shell: queues beats, requests only with a whole burst queued, holds req
// until the burst's last beat leaves. ARB_REQ_RELEASE_EN inserts a one-cycle req gap after each burst.
module arb_requester #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  arb_requester_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE
`ifdef ARB_REQ_RELEASE_EN
    , GAP
`endif
  } state_t;

  beat_t         r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count, r_bcnt;
  state_t        r_state;
  logic          r_req;
  logic          r_ovf;

  logic          w_full, w_push, w_pop, w_push_last, w_pop_last;
  logic [CW-1:0] w_count_nxt, w_bcnt_nxt;
  beat_t         w_head;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_push      = bus.in_valid & ~w_full;
  assign w_head      = r_mem[r_rptr];
  // req is only high with a whole burst queued, so a granted cycle always has a head beat
  assign w_pop       = r_req & bus.gnt;
  assign w_push_last = w_push & bus.in_last;
  assign w_pop_last  = w_pop & w_head.last;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (w_pop && !w_push) w_count_nxt = r_count - CW'(1);
  end

  always_comb begin
    w_bcnt_nxt = r_bcnt;
    if (w_push_last && !w_pop_last)      w_bcnt_nxt = r_bcnt + CW'(1);
    else if (w_pop_last && !w_push_last) w_bcnt_nxt = r_bcnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{last: bus.in_last, data: bus.in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_bcnt  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_bcnt  <= w_bcnt_nxt;
      // a full FIFO holding no burst end can never drain
      if (w_count_nxt == CW'(DEPTH) && w_bcnt_nxt == '0) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_bcnt_nxt != '0) begin
            r_state <= ACTIVE;
            r_req   <= 1'b1;
          end
        end
        ACTIVE: begin
`ifdef ARB_REQ_RELEASE_EN
          if (w_pop_last) begin
            r_state <= GAP;
            r_req   <= 1'b0;
          end
`else
          if (w_pop_last && w_bcnt_nxt == '0) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
          end
`endif
        end
`ifdef ARB_REQ_RELEASE_EN
        GAP: begin
          if (r_bcnt != '0) begin
            r_state <= ACTIVE;
            r_req   <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_req   <= 1'b0;
          end
        end
`endif
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ~w_full;
  assign bus.req       = r_req;
  assign bus.out_valid = w_pop;
  assign bus.out_data  = w_head.data;
  assign bus.out_last  = w_head.last;
  assign bus.burst_cnt = r_bcnt;
  assign bus.ovf_err   = r_ovf;
endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: beats accepted upstream go to a scoreboard queue, the bus monitor pops them.
module tb_arb_requester;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int LIMIT  = 64;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic gnt_en = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  arb_requester_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus();

  arb_requester #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // arbiter stand-in: grant follows req in the same cycle unless the test withholds it
  assign bus.gnt = bus.req & gnt_en;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL stale_beat: got last=%b data=%h, expected no beat", bus.out_last, bus.out_data);
      end else begin
        e = sb.pop_front();
        if ({bus.out_last, bus.out_data} !== e) begin
          failures++;
          $display("FAIL beat_order: got last=%b data=%h, expected last=%b data=%h",
                   bus.out_last, bus.out_data, e.last, e.data);
        end
      end
    end
  end

  task automatic push(input logic [DATA_W-1:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    if (bus.in_ready === 1'b1) sb.push_back({l, d});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_until_idle(output int n);
    n = 0;
    while ((sb.size() != 0 || bus.req === 1'b1) && n < LIMIT) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; gnt_en = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b, expected 0", bus.req); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
    checks++; if (bus.burst_cnt !== CW'(0)) begin failures++; $display("FAIL reset_burst_cnt: got %0d, expected 0", bus.burst_cnt); end
    checks++; if (bus.ovf_err !== 1'b0) begin failures++; $display("FAIL reset_ovf_err: got %b, expected 0", bus.ovf_err); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_burst;
    gnt_en = 1'b1;
    push(16'h00A1, 1'b0);
    push(16'h00A2, 1'b0);
    checks++; if (bus.req !== 1'b0) begin failures++; $display("FAIL basic_req_early: got %b, expected 0", bus.req); end
    push(16'h00A3, 1'b1);
    checks++; if (bus.req !== 1'b1) begin failures++; $display("FAIL basic_req_rise: got %b, expected 1", bus.req); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_last !== (i == 2)) begin
        failures++;
        $display("FAIL basic_beat%0d: got valid=%b last=%b, expected valid=1 last=%b", i, bus.out_valid, bus.out_last, (i == 2));
      end
    end
    @(negedge clk); #1;
    checks++; if (bus.req !== 1'b0) begin failures++; $display("FAIL basic_req_fall: got %b, expected 0", bus.req); end
    checks++; if (bus.burst_cnt !== CW'(0)) begin failures++; $display("FAIL basic_burst_cnt: got %0d, expected 0", bus.burst_cnt); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL basic_drained: got %0d pending, expected 0", sb.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_partial_burst;
    int n;
    gnt_en = 1'b0;
    push(16'h00B1, 1'b0);
    push(16'h00B2, 1'b0);
    @(negedge clk);
    checks++; if (bus.req !== 1'b0) begin failures++; $display("FAIL partial_req_low: got %b, expected 0", bus.req); end
    checks++; if (bus.burst_cnt !== CW'(0)) begin failures++; $display("FAIL partial_cnt0: got %0d, expected 0", bus.burst_cnt); end
    @(posedge clk); #1;
    push(16'h00B3, 1'b1);
    checks++; if (bus.req !== 1'b1) begin failures++; $display("FAIL partial_req_rise: got %b, expected 1", bus.req); end
    checks++; if (bus.burst_cnt !== CW'(1)) begin failures++; $display("FAIL partial_cnt1: got %0d, expected 1", bus.burst_cnt); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL partial_no_gnt: got %b, expected 0", bus.out_valid); end
    @(posedge clk); #1;
    gnt_en = 1'b1;
    run_until_idle(n);
    checks++; if (n >= LIMIT) begin failures++; $display("FAIL partial_timeout: got %0d cycles, expected < %0d", n, LIMIT); end
    checks++; if (bus.burst_cnt !== CW'(0)) begin failures++; $display("FAIL partial_cnt_end: got %0d, expected 0", bus.burst_cnt); end
  endtask

  task automatic test_gnt_drop;
    int n;
    gnt_en = 1'b0;
    push(16'h00C1, 1'b0);
    push(16'h00C2, 1'b0);
    push(16'h00C3, 1'b0);
    push(16'h00C4, 1'b1);
    gnt_en = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    gnt_en = 1'b0;
    @(negedge clk);
    checks++; if (bus.req !== 1'b1) begin failures++; $display("FAIL drop_req_held: got %b, expected 1", bus.req); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL drop_out_valid: got %b, expected 0", bus.out_valid); end
    checks++; if (sb.size() != 3) begin failures++; $display("FAIL drop_pending: got %0d, expected 3", sb.size()); end
    @(posedge clk); #1;
    gnt_en = 1'b1;
    run_until_idle(n);
    checks++; if (n >= LIMIT) begin failures++; $display("FAIL drop_timeout: got %0d cycles, expected < %0d", n, LIMIT); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL drop_drained: got %0d pending, expected 0", sb.size()); end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [4:0] ov, rq, exp_pat;
`ifdef ARB_REQ_RELEASE_EN
    exp_pat = 5'b11011;
`else
    exp_pat = 5'b11110;
`endif
    gnt_en = 1'b0;
    push(16'h00D1, 1'b0);
    push(16'h00D2, 1'b1);
    push(16'h00D3, 1'b0);
    push(16'h00D4, 1'b1);
    checks++; if (bus.burst_cnt !== CW'(2)) begin failures++; $display("FAIL b2b_cnt: got %0d, expected 2", bus.burst_cnt); end
    gnt_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ov[4-i] = bus.out_valid;
      rq[4-i] = bus.req;
    end
    checks++; if (ov !== exp_pat) begin failures++; $display("FAIL b2b_out_valid: got %b, expected %b", ov, exp_pat); end
    checks++; if (rq !== exp_pat) begin failures++; $display("FAIL b2b_req: got %b, expected %b", rq, exp_pat); end
    @(posedge clk); #1;
    run_until_idle(n);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_drained: got %0d pending, expected 0", sb.size()); end
  endtask

  task automatic test_overflow;
    gnt_en = 1'b0;
    push(16'h00E1, 1'b0);
    push(16'h00E2, 1'b0);
    push(16'h00E3, 1'b0);
    checks++; if (bus.ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b, expected 0", bus.ovf_err); end
    push(16'h00E4, 1'b0);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL ovf_in_ready: got %b, expected 0", bus.in_ready); end
    checks++; if (bus.ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b, expected 1", bus.ovf_err); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (bus.ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b, expected 1", bus.ovf_err); end
    @(negedge clk); rst_n = 1'b0; sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_cleared: got %b, expected 0", bus.ovf_err); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL ovf_ready_back: got %b, expected 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_burst;
    int n;
    int stale;
    gnt_en = 1'b1;
    push(16'h00F1, 1'b0);
    push(16'h00F2, 1'b0);
    push(16'h00F3, 1'b1);
    @(negedge clk);
    @(posedge clk); #2;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL mid_active: got %b, expected 1", bus.out_valid); end
    rst_n = 1'b0; sb.delete();
    #1;
    checks++; if (bus.req !== 1'b0) begin failures++; $display("FAIL mid_req_async: got %b, expected 0", bus.req); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid_async: got %b, expected 0", bus.out_valid); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.burst_cnt !== CW'(0)) begin failures++; $display("FAIL mid_burst_cnt: got %0d, expected 0", bus.burst_cnt); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready: got %b, expected 1", bus.in_ready); end
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.req !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin failures++; $display("FAIL mid_no_stale: got %0d active cycles, expected 0", stale); end
    @(posedge clk); #1;
    push(16'h0071, 1'b1);
    run_until_idle(n);
    checks++; if (n >= LIMIT || sb.size() != 0) begin failures++; $display("FAIL mid_recover: got %0d cycles %0d pending, expected drained", n, sb.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_burst();
    test_partial_burst();
    test_gnt_drop();
    test_back_to_back();
    test_overflow();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
